// File: rtl/riscv_pkg.sv
// Shared definitions for the five-stage RISC-V core: opcodes, ALU encodings,
// the decoder control word and the halt sequencer state type.
package riscv_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RT   = 7'b0110011;
    localparam logic [6:0] OP_BT   = 7'b1100011;
    localparam logic [6:0] OP_IT   = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       jump_sel;
        logic       alu_src;
        logic       beq;
        logic       bne;
        logic       blt;
        logic       bge;
        logic       done;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } halt_state_t;

endpackage

// File: rtl/id_ex_stage_halt_sequencer.sv
// Halt sequencer: after a captured `done`, counts execute edges until the
// pipeline has drained, masking younger instructions meanwhile.
module halt_sequencer
    import riscv_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic done_capture,
    input  logic stall,
    output logic halted,
    output logic mask
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    halt_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             halted_r;
    logic             mask_r;

    // State, drain counter and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RUN;
            cnt_r    <= {CNT_W{1'b0}};
            halted_r <= 1'b0;
            mask_r   <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (done_capture) begin
                        state_r <= DRAIN;
                        cnt_r   <= {CNT_W{1'b0}};
                        mask_r  <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Stalled edges do not advance the drain; flushes still do.
                    if (!stall) begin
                        if (cnt_r == CNT_LAST) begin
                            state_r  <= HALTED;
                            halted_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                HALTED: begin
                    state_r  <= HALTED;
                    halted_r <= 1'b1;
                    mask_r   <= 1'b1;
                end
                default: begin
                    state_r  <= RUN;
                    cnt_r    <= {CNT_W{1'b0}};
                    halted_r <= 1'b0;
                    mask_r   <= 1'b0;
                end
            endcase
        end
    end

    assign halted = halted_r;
    assign mask   = mask_r;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, stall hold and a halt
// sequencer that drains the pipeline after a valid `done`.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            FlushE,
    input  logic            StallE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            JumpSelD,
    input  logic            ALUSrcD,
    input  logic            BeqD,
    input  logic            BneD,
    input  logic            BltD,
    input  logic            BgeD,
    input  logic            doneD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            JumpSelE,
    output logic            ALUSrcE,
    output logic            BeqE,
    output logic            BneE,
    output logic            BltE,
    output logic            BgeE,
    output logic            doneE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            Halted
);

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_bundle_t;

    ex_bundle_t bank_r;
    ex_bundle_t capture_s;
    ex_bundle_t bank_next_s;
    logic       mask_s;
    logic       done_capture_s;

    assign done_capture_s = ValidD & doneD & ~FlushE & ~StallE;

    halt_sequencer #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_halt_sequencer (
        .clk          (clk),
        .rst_n        (rst_n),
        .done_capture (done_capture_s),
        .stall        (StallE),
        .halted       (Halted),
        .mask         (mask_s)
    );

    // Decode-side word; an invalid slot collapses to an all-zero bubble.
    always_comb begin
        capture_s = '0;
        if (ValidD) begin
            capture_s.valid            = 1'b1;
            capture_s.ctrl.reg_write   = RegWriteD;
            capture_s.ctrl.mem_write   = MemWriteD;
            capture_s.ctrl.jump        = JumpD;
            capture_s.ctrl.jump_sel    = JumpSelD;
            capture_s.ctrl.alu_src     = ALUSrcD;
            capture_s.ctrl.beq         = BeqD;
            capture_s.ctrl.bne         = BneD;
            capture_s.ctrl.blt         = BltD;
            capture_s.ctrl.bge         = BgeD;
            capture_s.ctrl.done        = doneD;
            capture_s.ctrl.result_src  = ResultSrcD;
            capture_s.ctrl.alu_control = ALUControlD;
            capture_s.rd1              = RD1D;
            capture_s.rd2              = RD2D;
            capture_s.pc               = PCD;
            capture_s.pc_plus4         = PCPlus4D;
            capture_s.imm              = ImmExtD;
            capture_s.rs1              = Rs1D;
            capture_s.rs2              = Rs2D;
            capture_s.rd               = RdD;
        end else begin
            capture_s = '0;
        end
    end

    // Next bank contents: flush, then hold, then halt masking, then capture.
    always_comb begin
        bank_next_s = '0;
        if (FlushE) begin
            bank_next_s = '0;
        end else if (StallE) begin
            bank_next_s = bank_r;
        end else if (mask_s) begin
            bank_next_s = '0;
        end else begin
            bank_next_s = capture_s;
        end
    end

    // The pipeline register itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r <= '0;
        end else begin
            bank_r <= bank_next_s;
        end
    end

    assign ValidE      = bank_r.valid;
    assign RegWriteE   = bank_r.ctrl.reg_write;
    assign MemWriteE   = bank_r.ctrl.mem_write;
    assign JumpE       = bank_r.ctrl.jump;
    assign JumpSelE    = bank_r.ctrl.jump_sel;
    assign ALUSrcE     = bank_r.ctrl.alu_src;
    assign BeqE        = bank_r.ctrl.beq;
    assign BneE        = bank_r.ctrl.bne;
    assign BltE        = bank_r.ctrl.blt;
    assign BgeE        = bank_r.ctrl.bge;
    assign doneE       = bank_r.ctrl.done;
    assign ResultSrcE  = bank_r.ctrl.result_src;
    assign ALUControlE = bank_r.ctrl.alu_control;
    assign RD1E        = bank_r.rd1;
    assign RD2E        = bank_r.rd2;
    assign PCE         = bank_r.pc;
    assign PCPlus4E    = bank_r.pc_plus4;
    assign ImmExtE     = bank_r.imm;
    assign Rs1E        = bank_r.rs1;
    assign Rs2E        = bank_r.rs2;
    assign RdE         = bank_r.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model
// of the D->E register and the drain-then-halt rule.
module tb_id_ex_stage;

    localparam int DRAIN = 3;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mw;
        logic        jump;
        logic        jsel;
        logic        alusrc;
        logic        beq;
        logic        bne;
        logic        blt;
        logic        bge;
        logic        done;
        logic [1:0]  rsrc;
        logic [2:0]  aluc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } stage_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   flush = 1'b0;
    logic   stall = 1'b0;
    stage_t din = '0;
    stage_t obs_e;

    logic ValidE, RegWriteE, MemWriteE, JumpE, JumpSelE, ALUSrcE;
    logic BeqE, BneE, BltE, BgeE, doneE, Halted;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;

    // Model state: expected E contents and the drain/halt bookkeeping.
    stage_t exp_e = '0;
    bit     m_drain = 1'b0;
    bit     m_halted = 1'b0;
    int     m_left = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .FlushE(flush), .StallE(stall),
        .ValidD(din.valid), .RegWriteD(din.rw), .MemWriteD(din.mw),
        .JumpD(din.jump), .JumpSelD(din.jsel), .ALUSrcD(din.alusrc),
        .BeqD(din.beq), .BneD(din.bne), .BltD(din.blt), .BgeD(din.bge),
        .doneD(din.done), .ResultSrcD(din.rsrc), .ALUControlD(din.aluc),
        .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc), .PCPlus4D(din.pc4),
        .ImmExtD(din.imm), .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .JumpSelE(JumpSelE), .ALUSrcE(ALUSrcE),
        .BeqE(BeqE), .BneE(BneE), .BltE(BltE), .BgeE(BgeE),
        .doneE(doneE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .Halted(Halted)
    );

    assign obs_e = {ValidE, RegWriteE, MemWriteE, JumpE, JumpSelE, ALUSrcE,
                    BeqE, BneE, BltE, BgeE, doneE, ResultSrcE, ALUControlE,
                    RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural view of one clock edge using the inputs present at that edge.
    task automatic model_edge();
        stage_t nxt;
        if (flush)                     nxt = '0;
        else if (stall)                nxt = exp_e;
        else if (m_drain || m_halted)  nxt = '0;
        else if (din.valid)            nxt = din;
        else                           nxt = '0;
        if (m_drain) begin
            if (!stall) begin
                m_left--;
                if (m_left == 0) begin
                    m_drain  = 1'b0;
                    m_halted = 1'b1;
                end
            end
        end else if (!m_halted && din.valid && din.done && !flush && !stall) begin
            m_drain = 1'b1;
            m_left  = DRAIN;
        end
        exp_e = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ebundle", obs_e, exp_e);
        check("halted", Halted, m_halted);
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        exp_e = '0;
        m_drain = 1'b0;
        m_halted = 1'b0;
        m_left = 0;
        #1;
        check("rst_ebundle", obs_e, 256'd0);
        check("rst_halted", Halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_in();
        din.valid  = ($urandom_range(0, 3) != 0);
        din.rw     = $urandom_range(0, 1);
        din.mw     = $urandom_range(0, 1);
        din.jump   = $urandom_range(0, 1);
        din.jsel   = $urandom_range(0, 1);
        din.alusrc = $urandom_range(0, 1);
        din.beq    = $urandom_range(0, 1);
        din.bne    = $urandom_range(0, 1);
        din.blt    = $urandom_range(0, 1);
        din.bge    = $urandom_range(0, 1);
        din.done   = ($urandom_range(0, 15) == 0);
        din.rsrc   = 2'($urandom_range(0, 3));
        din.aluc   = 3'($urandom_range(0, 7));
        din.rd1    = $urandom;
        din.rd2    = $urandom;
        din.pc     = $urandom;
        din.pc4    = $urandom;
        din.imm    = $urandom;
        din.rs1    = 5'($urandom_range(0, 31));
        din.rs2    = 5'($urandom_range(0, 31));
        din.rd     = 5'($urandom_range(0, 31));
        flush      = ($urandom_range(0, 7) == 0);
        stall      = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b1;

        // Reset is asynchronous: load a full word, then drop rst_n mid-cycle.
        din = '1;
        step();
        check("pre_rst_valid", ValidE, 1'b1);
        din = '1;
        flush = 1'b1;
        stall = 1'b1;
        pulse_reset();
        flush = 1'b0;
        stall = 1'b0;

        // Capture, hold under stall, flush beats stall.
        din = '0;
        din.valid = 1'b1;
        din.rw = 1'b1;
        din.rd1 = 32'h12345678;
        din.rd = 5'd5;
        step();
        check("cap_regwrite", RegWriteE, 1'b1);
        check("cap_rd1", RD1E, 32'h12345678);
        check("cap_rd", RdE, 5'd5);
        for (int i = 0; i < 2; i++) begin
            rand_in();
            din.done = 1'b0;
            flush = 1'b0;
            stall = 1'b1;
            step();
            check("stall_rd1", RD1E, 32'h12345678);
            check("stall_rd", RdE, 5'd5);
        end
        flush = 1'b1;
        stall = 1'b1;
        step();
        check("flush_regwrite", RegWriteE, 1'b0);
        check("flush_rd1", RD1E, 32'd0);
        flush = 1'b0;
        stall = 1'b0;

        // Invalid slot with done set must not start a halt.
        din = '0;
        din.done = 1'b1;
        din.mw = 1'b1;
        step();
        check("inv_valid", ValidE, 1'b0);
        check("inv_memwrite", MemWriteE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("inv_halted", Halted, 1'b0);
        end

        // Valid done, then younger sw instructions that must be masked.
        din = '0;
        din.valid = 1'b1;
        din.done = 1'b1;
        step();
        check("drain_done", doneE, 1'b1);
        din = '0;
        din.valid = 1'b1;
        din.mw = 1'b1;
        din.rd2 = 32'hCAFE0001;
        for (int i = 1; i <= DRAIN; i++) begin
            step();
            check("drain_sw_masked", MemWriteE, 1'b0);
            check("drain_halted", Halted, (i == DRAIN) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            check("halted_sticky", Halted, 1'b1);
            check("halted_masked", MemWriteE, 1'b0);
        end

        // One stall during drain delays Halted by one edge.
        pulse_reset();
        din = '0;
        din.valid = 1'b1;
        din.done = 1'b1;
        step();
        stall = 1'b1;
        step();
        stall = 1'b0;
        for (int i = 2; i <= DRAIN + 1; i++) begin
            step();
            check("stall_drain_halted", Halted, (i == DRAIN + 1) ? 1'b1 : 1'b0);
        end

        // Reset out of HALTED, then an add passes normally.
        pulse_reset();
        din = '0;
        din.valid = 1'b1;
        din.rw = 1'b1;
        din.aluc = 3'b000;
        din.rs1 = 5'd1;
        din.rs2 = 5'd2;
        din.rd = 5'd3;
        din.rd1 = $urandom;
        din.rd2 = $urandom;
        step();
        check("add_valid", ValidE, 1'b1);
        check("add_regwrite", RegWriteE, 1'b1);
        check("add_aluc", ALUControlE, 3'b000);
        check("add_rd", RdE, 5'd3);

        // Random traffic against the model, with occasional resets.
        for (int n = 0; n < 800; n++) begin
            if (n % 97 == 96) begin
                pulse_reset();
            end
            rand_in();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
